// File: rtl/norm_reader_if.sv
// Valid/ready stream bundle shared by the norm_reader
// pixel input and normalized pixel output.
interface norm_reader_if #(
  parameter int W = 8
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;

  modport master (
    output tvalid,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/norm_reader.sv
// Frame buffer behind the crop filter: stores one frame, divides
// full scale by the frame maximum, then streams pixels rescaled.
module norm_reader #(
  parameter int OUT_ROWS = 10,
  parameter int OUT_COLS = 10,
  parameter int OUT_W    = 8,
  parameter int FRAC_W   = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  norm_reader_if.slave  s_axis,
  input  logic [7:0] max_value,
  input  logic       max_value_tvalid,
  output logic       ap_ready,
  output logic       ap_done,
  norm_reader_if.master m_axis,
  output logic       m_axis_tlast
);

  localparam int N  = OUT_ROWS * OUT_COLS;
  localparam int CW = $clog2(N) + 1;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = OUT_W + FRAC_W;
  localparam int KW = $clog2(DW) + 1;
  localparam int PW = 8 + DW + 1;
  localparam int SW = PW - FRAC_W;

  localparam logic [OUT_W-1:0] FULL = '1;
  localparam logic [PW-1:0] HALF = PW'(1) << (FRAC_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DIV,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
  logic             max_seen_q, max_seen_d;
  logic [7:0]       max_reg_q, max_reg_d;
  logic             max_tv_q, max_tv_d;
  logic [DW-1:0]    recip_q, recip_d;
  logic [7:0]       rem_q, rem_d;
  logic [KW-1:0]    div_cnt_q, div_cnt_d;
  logic             s1_v_q, s1_v_d;
  logic             s1_last_q, s1_last_d;
  logic             tvalid_q, tvalid_d;
  logic [OUT_W-1:0] tdata_q, tdata_d;
  logic             tlast_q, tlast_d;
  logic             done_q, done_d;
  logic             s_rdy_q, s_rdy_d;

  logic [7:0] mem [N];
  logic [7:0] ram_q;

  logic             s_hs;
  logic             m_hs;
  logic             stall;
  logic             rd_en;
  logic             div_bit;
  logic [8:0]       rem_sh;
  logic             ge;
  logic [SW-1:0]    scaled;
  logic [OUT_W-1:0] sat;

  assign s_hs  = s_axis.tvalid & s_rdy_q;
  assign m_hs  = tvalid_q & m_axis.tready;
  assign stall = tvalid_q & ~m_axis.tready;
  assign rd_en = (state_q == DRAIN) & ~stall
               & (rd_cnt_q < CW'(N));

  // Dividend is FULL followed by FRAC_W zeros, fed MSB first.
  assign div_bit = div_cnt_q < KW'(OUT_W);
  assign rem_sh  = {rem_q, div_bit};
  assign ge      = rem_sh >= {1'b0, max_reg_q};

  assign scaled = SW'((PW'(ram_q) * PW'(recip_q) + HALF)
                      >> FRAC_W);
  assign sat    = (|scaled[SW-1:OUT_W]) ? FULL
                : scaled[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (s_hs) begin
      mem[wr_cnt_q[AW-1:0]] <= s_axis.tdata;
    end
    if (rd_en) begin
      ram_q <= mem[rd_cnt_q[AW-1:0]];
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    max_seen_d = max_seen_q;
    max_reg_d  = max_reg_q;
    max_tv_d   = max_value_tvalid;
    recip_d    = recip_q;
    rem_d      = rem_q;
    div_cnt_d  = div_cnt_q;
    s1_v_d     = s1_v_q;
    s1_last_d  = s1_last_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    done_d     = 1'b0;

    // Only a fresh edge counts; a level left over is stale.
    if (max_value_tvalid && !max_tv_q &&
        (state_q == IDLE || state_q == FILL)) begin
      max_seen_d = 1'b1;
      max_reg_d  = max_value;
    end

    unique case (state_q)
      IDLE: begin
        if (s_hs) begin
          wr_cnt_d = CW'(1);
          state_d  = (N == 1 && max_seen_d) ? DIV : FILL;
        end
      end
      FILL: begin
        if (s_hs) begin
          wr_cnt_d = wr_cnt_q + CW'(1);
        end
        if (wr_cnt_q == CW'(N) && max_seen_q) begin
          state_d = DIV;
        end
      end
      DIV: begin
        if (max_reg_q == 8'd0) begin
          recip_d = '0;
          state_d = DRAIN;
        end else begin
          rem_d     = ge ? 8'(rem_sh - {1'b0, max_reg_q})
                         : rem_sh[7:0];
          recip_d   = {recip_q[DW-2:0], ge};
          div_cnt_d = div_cnt_q + KW'(1);
          if (div_cnt_q == KW'(DW - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (rd_en) begin
          rd_cnt_d = rd_cnt_q + CW'(1);
        end
        if (!stall) begin
          s1_v_d    = rd_en;
          s1_last_d = rd_en & (rd_cnt_q == CW'(N - 1));
          tvalid_d  = s1_v_q;
          tlast_d   = s1_v_q & s1_last_q;
          if (s1_v_q) begin
            tdata_d = sat;
          end
        end
        if (m_hs && tlast_q) begin
          done_d     = 1'b1;
          state_d    = IDLE;
          wr_cnt_d   = '0;
          rd_cnt_d   = '0;
          max_seen_d = 1'b0;
          s1_v_d     = 1'b0;
          s1_last_d  = 1'b0;
          tvalid_d   = 1'b0;
          tlast_d    = 1'b0;
        end
      end
    endcase

    if (state_q != DIV && state_d == DIV) begin
      div_cnt_d = '0;
      rem_d     = '0;
      recip_d   = '0;
    end

    s_rdy_d = (state_d == IDLE)
            | ((state_d == FILL) & (wr_cnt_d < CW'(N)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      max_seen_q <= 1'b0;
      max_reg_q  <= '0;
      max_tv_q   <= 1'b0;
      recip_q    <= '0;
      rem_q      <= '0;
      div_cnt_q  <= '0;
      s1_v_q     <= 1'b0;
      s1_last_q  <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      done_q     <= 1'b0;
      s_rdy_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      max_seen_q <= max_seen_d;
      max_reg_q  <= max_reg_d;
      max_tv_q   <= max_tv_d;
      recip_q    <= recip_d;
      rem_q      <= rem_d;
      div_cnt_q  <= div_cnt_d;
      s1_v_q     <= s1_v_d;
      s1_last_q  <= s1_last_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      done_q     <= done_d;
      s_rdy_q    <= s_rdy_d;
    end
  end

  assign ap_ready      = (state_q == IDLE);
  assign ap_done       = done_q;
  assign s_axis.tready = s_rdy_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_norm_reader.sv
// Directed bench for norm_reader: ramp, early max, zero frame,
// output backpressure, stale max level and mid-drain reset.
module tb_norm_reader;
  localparam int N = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] max_value = 8'd0;
  logic       max_value_tvalid = 1'b0;
  logic       ap_ready;
  logic       ap_done;
  logic       m_axis_tlast;

  norm_reader_if #(.W(8)) s_if ();
  norm_reader_if #(.W(8)) m_if ();

  norm_reader #(
    .OUT_ROWS(10),
    .OUT_COLS(10),
    .OUT_W(8),
    .FRAC_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .s_axis(s_if),
    .max_value(max_value),
    .max_value_tvalid(max_value_tvalid),
    .ap_ready(ap_ready),
    .ap_done(ap_done),
    .m_axis(m_if),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int pix[N];
  int got[N];
  int ref0[N];
  int cyc;

  function automatic int exp_of(input int p, input int mx);
    longint r;
    longint v;
    if (mx == 0) return 0;
    r = (longint'(255) << 16) / mx;
    v = (longint'(p) * r + 32768) >> 16;
    return (v > 255) ? 255 : int'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input int lo, input int hi,
                            input int mval);
    int n;
    for (int i = 0; i < N; i++) begin
      if (i == lo) max_value_tvalid = 1'b0;
      if (i == hi) begin
        max_value_tvalid = 1'b1;
        max_value = 8'(mval);
      end
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'(pix[i]);
      n = 0;
      while (!s_if.tready && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("s_tready", 32'(s_if.tready), 1);
      @(negedge clk);
    end
    s_if.tvalid = 1'b0;
    if (hi >= N) begin
      max_value_tvalid = 1'b1;
      max_value = 8'(mval);
    end
  endtask

  task automatic wait_valid(input int lat);
    int n;
    n = 0;
    while (!m_if.tvalid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, lat);
    chk("busy_ap_ready", 32'(ap_ready), 0);
  endtask

  task automatic collect(input int mx, input int limit,
                         input int rmode);
    int   idx;
    bit   hold;
    bit   rdy;
    logic [7:0] hd;
    logic hl;
    idx = 0;
    hold = 1'b0;
    cyc = 0;
    while (idx < limit && cyc < 3000) begin
      if (hold) begin
        chk("hold_valid", 32'(m_if.tvalid), 1);
        chk("hold_data", 32'(m_if.tdata), 32'(hd));
        chk("hold_last", 32'(m_axis_tlast), 32'(hl));
      end
      rdy = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      m_if.tready = rdy;
      hold = 1'b0;
      if (m_if.tvalid) begin
        if (rdy) begin
          chk("data", 32'(m_if.tdata), exp_of(pix[idx], mx));
          chk("tlast", 32'(m_axis_tlast), 32'(idx == N - 1));
          got[idx] = int'(m_if.tdata);
          idx++;
        end else begin
          hold = 1'b1;
          hd = m_if.tdata;
          hl = m_axis_tlast;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("beats", idx, limit);
    m_if.tready = 1'b1;
  endtask

  task automatic frame_end();
    chk("ap_done", 32'(ap_done), 1);
    chk("valid_off", 32'(m_if.tvalid), 0);
    @(negedge clk);
    chk("ap_done_pulse", 32'(ap_done), 0);
    chk("ap_ready", 32'(ap_ready), 1);
    chk("s_tready_idle", 32'(s_if.tready), 1);
  endtask

  task automatic run_frame(input int lo, input int hi,
                           input int mval, input int mx,
                           input int lat, input int rmode);
    send_frame(lo, hi, mval);
    wait_valid(lat);
    collect(mx, N, rmode);
    frame_end();
  endtask

  initial begin
    int mx;
    s_if.tvalid = 1'b0;
    s_if.tdata  = 8'd0;
    m_if.tready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_m_valid", 32'(m_if.tvalid), 0);
    chk("rst_m_data", 32'(m_if.tdata), 0);
    chk("rst_m_last", 32'(m_axis_tlast), 0);
    chk("rst_ap_done", 32'(ap_done), 0);
    chk("rst_s_tready", 32'(s_if.tready), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_ap_ready", 32'(ap_ready), 1);
    chk("idle_s_tready", 32'(s_if.tready), 1);

    // Ramp, late max of 99
    for (int i = 0; i < N; i++) pix[i] = i;
    run_frame(0, N, 99, 99, 28, 0);
    chk("throughput", cyc, N);
    chk("ramp_p99", got[99], 255);
    chk("ramp_p50", got[50], 129);
    chk("ramp_p0", got[0], 0);
    chk("ramp_p1", got[1], 3);

    // Max edge arrives mid-frame
    for (int i = 0; i < N; i++) pix[i] = 2 * i;
    pix[37] = 200;
    run_frame(0, 50, 200, 200, 27, 0);
    chk("early_p200", got[37], 255);
    chk("early_p2", got[1], 3);
    chk("early_p100", got[50], 127);

    // All-zero frame with zero max
    for (int i = 0; i < N; i++) pix[i] = 0;
    run_frame(0, N, 0, 0, 5, 0);
    chk("zero_p0", got[0], 0);
    chk("zero_p99", got[99], 0);

    // Random frame, ready held then toggled
    mx = 0;
    for (int i = 0; i < N; i++) begin
      pix[i] = int'($urandom_range(0, 255));
      if (pix[i] > mx) mx = pix[i];
    end
    run_frame(0, N, mx, mx, 28, 0);
    for (int i = 0; i < N; i++) ref0[i] = got[i];
    run_frame(0, N, mx, mx, 28, 1);
    for (int i = 0; i < N; i++) chk("bp_same", got[i], ref0[i]);

    // Stale level from frame A must not scale frame B
    mx = 0;
    for (int i = 0; i < N; i++) begin
      pix[i] = int'($urandom_range(0, 100));
      if (pix[i] > mx) mx = pix[i];
    end
    run_frame(0, N, mx, mx, 28, 0);
    max_value = 8'd250;
    for (int i = 0; i < N; i++) pix[i] = i % 41;
    run_frame(60, 70, 40, 40, 27, 0);
    chk("stale_p40", got[40], 255);
    chk("stale_p20", got[20], 128);

    // Reset after 37 output beats
    for (int i = 0; i < N; i++) pix[i] = i;
    send_frame(0, N, 99);
    wait_valid(28);
    collect(99, 37, 0);
    chk("pre_rst_valid", 32'(m_if.tvalid), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(m_if.tvalid), 0);
    chk("mid_rst_data", 32'(m_if.tdata), 0);
    chk("mid_rst_last", 32'(m_axis_tlast), 0);
    chk("mid_rst_done", 32'(ap_done), 0);
    chk("mid_rst_s_rdy", 32'(s_if.tready), 0);
    max_value_tvalid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) pix[i] = 99 - i;
    run_frame(0, N, 99, 99, 28, 0);
    chk("post_rst_p0", got[0], 255);
    chk("post_rst_p49", got[49], 129);
    chk("post_rst_p99", got[99], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
